pbvi_iter_sequencer: RTL and testbench

Top-level sequencer for one PBVI value-iteration run. It drives the step1 (projection), step2 (per-belief argmax backup) and step3 (action max / alpha update) datapaths in order, once per iteration, and commits the new alpha set after each iteration. It repeats for a programmed iteration count, with optional early exit on convergence. A per-stage watchdog reports a hung stage.

---
 rtl/pbvi_iter_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_pbvi_iter_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbvi_iter_sequencer.sv
// pbvi_iter_sequencer
// Top-level sequencer for one PBVI value-iteration run. It pulses the
// step1 / step2 / step3 datapath enables in order once per iteration, waits
// for each stage's done, and commits the new alpha set after each iteration.
// A per-stage watchdog moves the sequencer to ERR if a stage hangs.
//
// Optional feature macro: PBVI_CONVERGE_EN
//   defined   : conv_delta < conv_thresh sampled with step3_done sets a
//               convergence flag that ends the run early and drives converged.
//   undefined : conv_delta / conv_thresh are ignored, converged stays 0 and
//               every run executes exactly num_iter iterations.
`timescale 1ns/1ps

module pbvi_iter_sequencer #(
   parameter int ITER_W        = 8,
   parameter int STAGE_TIMEOUT = 255,
   parameter int TO_W          = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ITER_W-1:0] num_iter,
   output logic              step1_en,
   input  logic              step1_done,
   output logic              step2_en,
   input  logic              step2_done,
   output logic              step3_en,
   input  logic              step3_done,
   output logic              alpha_swap,
   input  logic [15:0]       conv_delta,
   input  logic [15:0]       conv_thresh,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              converged,
   output logic [ITER_W-1:0] iter_count
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_S1,
      ST_W1,
      ST_S2,
      ST_W2,
      ST_S3,
      ST_W3,
      ST_COMMIT,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [TO_W-1:0] TO_LIM = TO_W'(STAGE_TIMEOUT);

   state_t            state_q, state_d;
   logic [ITER_W-1:0] num_iter_q, num_iter_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic [TO_W-1:0]   wd_q, wd_d;
   logic [TO_W-1:0]   wd_inc;
   logic              wd_expired;
   logic              conv_flag_q, conv_flag_d;
   logic              converged_q, converged_d;
   logic              error_q, error_d;
   logic              step1_en_q, step2_en_q, step3_en_q;
   logic              alpha_swap_q, done_q, busy_q;
   logic              conv_hit;

`ifdef PBVI_CONVERGE_EN
   assign conv_hit = (conv_delta < conv_thresh);
`else
   logic unused_conv;
   assign conv_hit    = 1'b0;
   assign unused_conv = ^{conv_delta, conv_thresh};
`endif

   assign wd_inc     = wd_q + 1'b1;
   assign wd_expired = (wd_inc == TO_LIM);

   // Next-state and next-register computation for the whole sequencer.
   always_comb begin
      state_d     = state_q;
      num_iter_d  = num_iter_q;
      iter_d      = iter_q;
      wd_d        = wd_q;
      conv_flag_d = conv_flag_q;
      converged_d = converged_q;
      error_d     = error_q;

      unique case (state_q)
         ST_IDLE, ST_ERR: begin
            if (abort) begin
               // abort beats start; in ERR it also clears the sticky error
               state_d = ST_IDLE;
               error_d = 1'b0;
            end else if (start) begin
               error_d     = 1'b0;
               iter_d      = '0;
               conv_flag_d = 1'b0;
               converged_d = 1'b0;
               num_iter_d  = num_iter;
               state_d     = (num_iter == '0) ? ST_DONE : ST_S1;
            end
         end
         ST_S1: begin
            wd_d    = '0;
            state_d = ST_W1;
         end
         ST_W1: begin
            if (step1_done) begin
               state_d = ST_S2;
            end else if (wd_expired) begin
               state_d = ST_ERR;
               error_d = 1'b1;
            end else begin
               wd_d = wd_inc;
            end
         end
         ST_S2: begin
            wd_d    = '0;
            state_d = ST_W2;
         end
         ST_W2: begin
            if (step2_done) begin
               state_d = ST_S3;
            end else if (wd_expired) begin
               state_d = ST_ERR;
               error_d = 1'b1;
            end else begin
               wd_d = wd_inc;
            end
         end
         ST_S3: begin
            wd_d    = '0;
            state_d = ST_W3;
         end
         ST_W3: begin
            if (step3_done) begin
               // count is bumped on entry so it is visible alongside alpha_swap
               conv_flag_d = conv_hit;
               iter_d      = iter_q + 1'b1;
               state_d     = ST_COMMIT;
            end else if (wd_expired) begin
               state_d = ST_ERR;
               error_d = 1'b1;
            end else begin
               wd_d = wd_inc;
            end
         end
         ST_COMMIT: begin
            if ((iter_q == num_iter_q) || conv_flag_q) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_S1;
            end
         end
         ST_DONE: begin
            converged_d = conv_flag_q;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // abort while running discards whatever this cycle would have committed
      if (abort && (state_q inside {ST_S1, ST_W1, ST_S2, ST_W2, ST_S3, ST_W3, ST_COMMIT})) begin
         state_d     = ST_IDLE;
         iter_d      = iter_q;
         conv_flag_d = conv_flag_q;
         error_d     = error_q;
      end
   end

   // State register plus registered decodes of the next state for the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         num_iter_q   <= '0;
         iter_q       <= '0;
         wd_q         <= '0;
         conv_flag_q  <= 1'b0;
         converged_q  <= 1'b0;
         error_q      <= 1'b0;
         step1_en_q   <= 1'b0;
         step2_en_q   <= 1'b0;
         step3_en_q   <= 1'b0;
         alpha_swap_q <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         num_iter_q   <= num_iter_d;
         iter_q       <= iter_d;
         wd_q         <= wd_d;
         conv_flag_q  <= conv_flag_d;
         converged_q  <= converged_d;
         error_q      <= error_d;
         step1_en_q   <= (state_d == ST_S1);
         step2_en_q   <= (state_d == ST_S2);
         step3_en_q   <= (state_d == ST_S3);
         alpha_swap_q <= (state_d == ST_COMMIT);
         done_q       <= (state_d == ST_DONE);
         busy_q       <= !(state_d inside {ST_IDLE, ST_ERR, ST_DONE});
      end
   end

   assign step1_en   = step1_en_q;
   assign step2_en   = step2_en_q;
   assign step3_en   = step3_en_q;
   assign alpha_swap = alpha_swap_q;
   assign done       = done_q;
   assign busy       = busy_q;
   assign error      = error_q;
   assign converged  = converged_q;
   assign iter_count = iter_q;

endmodule

// File: tb/tb_pbvi_iter_sequencer.sv
// tb_pbvi_iter_sequencer
// Randomised and directed runs of the iteration sequencer. Each run's plan
// (iteration count, per-stage response delays, convergence metrics, abort
// cycle) is turned into a timeline of expected events by a behavioural model;
// a monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps

module tb_pbvi_iter_sequencer;

   localparam int ITER_W = 8;
   localparam int T      = 5;
   localparam int TO_W   = 8;

   localparam int K_EN1  = 1;
   localparam int K_EN2  = 2;
   localparam int K_EN3  = 3;
   localparam int K_SWAP = 4;
   localparam int K_DONE = 5;
   localparam int K_ERR  = 6;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ITER_W-1:0] num_iter = '0;
   logic [15:0]       conv_delta = '0;
   logic [15:0]       conv_thresh = '0;
   logic              step1_en, step2_en, step3_en, alpha_swap;
   logic              busy, done, error, converged;
   logic [ITER_W-1:0] iter_count;
   wire  [2:0]        done_w;
   wire  [2:0]        en_w = {step3_en, step2_en, step1_en};

   pbvi_iter_sequencer #(
      .ITER_W        (ITER_W),
      .STAGE_TIMEOUT (T),
      .TO_W          (TO_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .num_iter    (num_iter),
      .step1_en    (step1_en),
      .step1_done  (done_w[0]),
      .step2_en    (step2_en),
      .step2_done  (done_w[1]),
      .step3_en    (step3_en),
      .step3_done  (done_w[2]),
      .alpha_swap  (alpha_swap),
      .conv_delta  (conv_delta),
      .conv_thresh (conv_thresh),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .converged   (converged),
      .iter_count  (iter_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int kind;
      int cyc;
      int iter;
      int conv;
      int dly;
      int cd;
   } ev_t;

   ev_t sb[$];
   int  dq[3][$];
   int  cdq[$];

   int plan_d[16][3];
   int plan_dv[16];

   int model_iter = 0;
   int model_conv = 0;
   int model_err  = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic ev_t mk(input int k, input int c, input int it, input int cv,
                              input int dl, input int cd);
      ev_t e;
      e.kind = k; e.cyc = c; e.iter = it; e.conv = cv; e.dly = dl; e.cd = cd;
      return e;
   endfunction

   // Stage models: each answers its enable with a one-cycle done after the
   // planned delay (delay 1 = done in the cycle right after the enable).
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_resp
         logic done_r = 1'b0;
         assign done_w[gi] = done_r;
         initial begin
            int d;
            forever begin
               @(negedge clk);
               if (en_w[gi] === 1'b1) begin
                  d = (dq[gi].size() > 0) ? dq[gi].pop_front() : 1;
                  repeat (d) @(posedge clk);
                  #1 done_r = 1'b1;
                  @(posedge clk);
                  #1 done_r = 1'b0;
               end
            end
         end
      end
   endgenerate

   // The step3 metric for an iteration is presented from its step3_en onward.
   initial begin
      forever begin
         @(negedge clk);
         if (step3_en === 1'b1 && cdq.size() > 0) conv_delta = 16'(cdq.pop_front());
      end
   end

   task automatic expect_ev(input int k);
      ev_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d expected no event", k, cyc);
      end else begin
         e = sb.pop_front();
         checks++;
         if (e.kind != k || e.cyc != cyc) begin
            errors++;
            $display("FAIL event_order: got kind %0d at cycle %0d expected kind %0d at cycle %0d",
                     k, cyc, e.kind, e.cyc);
         end
         if (k == K_SWAP || (k == K_DONE && e.iter >= 0))
            chk("iter_count_at_event", int'(iter_count), e.iter);
         if (k == K_DONE) chk("converged_at_done", int'(converged), e.conv);
         if (k == K_DONE || k == K_ERR) chk("busy_low_at_end", int'(busy), 0);
         else chk("busy_high_in_run", int'(busy), 1);
         if (k == K_ERR) chk("error_set", int'(error), 1);
      end
   endtask

   // Monitor: every output event is matched against the expected timeline.
   initial begin
      logic err_prev;
      err_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (step1_en) expect_ev(K_EN1);
            if (step2_en) expect_ev(K_EN2);
            if (step3_en) expect_ev(K_EN3);
            if (alpha_swap) expect_ev(K_SWAP);
            if (done) expect_ev(K_DONE);
            if (error && !err_prev) expect_ev(K_ERR);
         end
         err_prev = error;
      end
   end

   task automatic set_plan(input int d1, input int d2, input int d3, input int dv);
      for (int i = 0; i < 16; i++) begin
         plan_d[i][0] = d1;
         plan_d[i][1] = d2;
         plan_d[i][2] = d3;
         plan_dv[i]   = dv;
      end
   endtask

   // One run: build the expected timeline from the plan, drive it, drain it.
   task automatic run_one(input int n, input int thr, input int abort_off);
      ev_t evs[$];
      int  b, t, a, fin_iter, fin_conv, budget, swaps_kept, stage_end;
      bit  stop, got_err, err_kept, done_kept;
      @(posedge clk);
      #1;
      b = cyc;
      a = (abort_off >= 0) ? b + abort_off : 32'h3fff_ffff;
      t = b + 1;
      fin_iter = 0;
      fin_conv = 0;
      stop = 1'b0;
      got_err = 1'b0;
      if (n == 0) begin
         evs.push_back(mk(K_DONE, b + 1, -1, 0, 0, 0));
      end else begin
         for (int i = 0; i < n && !stop; i++) begin
            for (int s = 0; s < 3 && !stop; s++) begin
               evs.push_back(mk(K_EN1 + s, t, 0, 0, plan_d[i][s], plan_dv[i]));
               if (plan_d[i][s] > T) begin
                  evs.push_back(mk(K_ERR, t + 1 + T, 0, 0, 0, 0));
                  got_err = 1'b1;
                  stop = 1'b1;
               end else begin
                  t = t + 1 + plan_d[i][s];
               end
            end
            if (!stop) begin
               fin_iter = i + 1;
               evs.push_back(mk(K_SWAP, t, i + 1, 0, 0, 0));
               t = t + 1;
`ifdef PBVI_CONVERGE_EN
               if (plan_dv[i] < thr) begin
                  fin_conv = 1;
                  stop = 1'b1;
               end
`endif
            end
         end
         if (!got_err) evs.push_back(mk(K_DONE, t, fin_iter, fin_conv, 0, 0));
      end

      swaps_kept = 0;
      err_kept = 1'b0;
      done_kept = 1'b0;
      stage_end = b;
      foreach (evs[i]) begin
         if (evs[i].cyc <= a) begin
            sb.push_back(evs[i]);
            stage_end = evs[i].cyc;
            if (evs[i].kind <= K_EN3) dq[evs[i].kind - 1].push_back(evs[i].dly);
            if (evs[i].kind == K_EN3) cdq.push_back(evs[i].cd);
            if (evs[i].kind == K_SWAP) swaps_kept++;
            if (evs[i].kind == K_ERR) err_kept = 1'b1;
            if (evs[i].kind == K_DONE) done_kept = 1'b1;
         end
      end
      if (a > b) begin
         model_iter = (n == 0) ? -1 : swaps_kept;
         model_conv = done_kept ? fin_conv : 0;
      end
      model_err = (err_kept && abort_off < 0) ? 1 : 0;

      $display("run n=%0d thr=%0d abort_off=%0d start_cycle=%0d expected_events=%0d last_at=%0d",
               n, thr, abort_off, b, sb.size(), stage_end);

      start = 1'b1;
      num_iter = ITER_W'(n);
      conv_thresh = 16'(thr);
      if (abort_off == 0) abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      if (abort_off > 0) begin
         while (cyc < a) begin
            @(posedge clk);
            #1;
         end
         abort = 1'b1;
         @(posedge clk);
         #1;
         abort = 1'b0;
      end

      budget = 2000;
      while (sb.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      chk("run_events_outstanding", sb.size(), 0);
      sb.delete();
      repeat (T + 8) @(posedge clk);
      #1;
      if (model_iter >= 0) chk("iter_count_hold", int'(iter_count), model_iter);
      chk("converged_hold", int'(converged), model_conv);
      chk("error_after_run", int'(error), model_err);
      chk("busy_after_run", int'(busy), 0);
   endtask

   initial begin
      #(10 * 80000);
      $display("FAIL global_timeout: got no finish expected finish before cycle 80000");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "simulation timeout");
   end

   initial begin
      int n, thr, ab, r, b;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_error", int'(error), 0);
      chk("reset_en1", int'(step1_en), 0);
      chk("reset_swap", int'(alpha_swap), 0);
      chk("reset_iter", int'(iter_count), 0);
      chk("reset_converged", int'(converged), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // all stages answer immediately: done at start+22 for three iterations
      set_plan(1, 1, 1, 5);
      run_one(3, 0, -1);
      // step2 answers 4 cycles after its enable
      set_plan(1, 4, 1, 5);
      run_one(2, 0, -1);
      // step1 never answers in time: watchdog fires
      set_plan(T + 1, 1, 1, 5);
      run_one(2, 0, -1);
      // start from ERR clears the error and runs normally
      set_plan(1, 1, 1, 5);
      run_one(1, 0, -1);
      // abort in W2 of the second iteration
      run_one(3, 0, 11);
      // first metric under threshold: early exit when the feature is built in
      set_plan(1, 1, 1, 3);
      run_one(10, 4, -1);
      // zero iterations
      run_one(0, 0, -1);
      // abort together with start
      set_plan(1, 1, 1, 5);
      run_one(2, 0, 0);
      // done exactly at the watchdog limit still advances
      set_plan(T, T, T, 9);
      run_one(1, 0, -1);
      // step3 hangs, then abort from ERR
      set_plan(1, 1, T + 1, 5);
      run_one(2, 0, 12);

      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < 3; s++) begin
               r = $urandom_range(0, 39);
               plan_d[i][s] = (r == 0) ? T + 1 : (r == 1) ? T : $urandom_range(1, 3);
            end
            plan_dv[i] = $urandom_range(0, 15);
         end
         n = $urandom_range(0, 4);
         thr = $urandom_range(0, 8);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
         run_one(n, thr, ab);
      end

      // reset in the middle of a run
      set_plan(1, 3, 1, 5);
      @(posedge clk);
      #1;
      b = cyc;
      sb.push_back(mk(K_EN1, b + 1, 0, 0, 1, 5));
      sb.push_back(mk(K_EN2, b + 3, 0, 0, 3, 5));
      dq[0].push_back(1);
      dq[1].push_back(3);
      start = 1'b1;
      num_iter = ITER_W'(3);
      @(posedge clk);
      #1;
      start = 1'b0;
      while (cyc < b + 4) begin
         @(posedge clk);
         #1;
      end
      #1;
      chk("busy_pre_reset", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_en2", int'(step2_en), 0);
      chk("midreset_iter", int'(iter_count), 0);
      chk("midreset_events_seen", sb.size(), 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("post_reset_busy", int'(busy), 0);
      chk("post_reset_done", int'(done), 0);
      chk("post_reset_error", int'(error), 0);
      dq[0].delete();
      dq[1].delete();
      dq[2].delete();
      cdq.delete();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
